tmr_regfile_scrub: RTL and testbench

//  Triple-redundant 3-port register file that feeds the voted ALU operands (rd1 -> a, rd2 -> b).

---
 rtl/tmr_regfile_scrub_pkg.sv | 16 +
 rtl/tmr_regfile_scrub_if.sv | 35 +++
 rtl/tmr_vote3.sv | 11 +
 rtl/tmr_regfile_scrub.sv | 164 ++++++++++++++++
 tb/tb_tmr_regfile_scrub.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tmr_regfile_scrub_pkg.sv
// Shared types and default sizing for the triple-redundant register file.
package tmr_regfile_scrub_pkg;

    localparam int unsigned DEF_WIDTH          = 32;
    localparam int unsigned DEF_AW             = 5;
    localparam int unsigned DEF_SCRUB_INTERVAL = 16;
    localparam int unsigned DEF_CNTW           = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        READ = 2'd2,
        FIX  = 2'd3
    } scrub_state_t;

endpackage

// File: rtl/tmr_regfile_scrub_if.sv
// CPU register-file ports, fault injection and scrub status grouped as one bundle.
interface tmr_regfile_scrub_if
    import tmr_regfile_scrub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned AW    = DEF_AW,
    parameter int unsigned CNTW  = DEF_CNTW
);
    logic             we3;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             scrub_en;
    logic             inj_en;
    logic [1:0]       inj_copy;
    logic [AW-1:0]    inj_addr;
    logic [WIDTH-1:0] inj_mask;
    logic             err_corrected;
    logic [AW-1:0]    err_addr;
    logic [CNTW-1:0]  err_count;
    logic             scrub_busy;

    modport slave (
        input  we3, ra1, ra2, wa3, wd3, scrub_en, inj_en, inj_copy, inj_addr, inj_mask,
        output rd1, rd2, err_corrected, err_addr, err_count, scrub_busy
    );

    modport master (
        output we3, ra1, ra2, wa3, wd3, scrub_en, inj_en, inj_copy, inj_addr, inj_mask,
        input  rd1, rd2, err_corrected, err_addr, err_count, scrub_busy
    );
endinterface

// File: rtl/tmr_vote3.sv
// Bitwise 2-of-3 majority voter.
module tmr_vote3 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    output logic [WIDTH-1:0] o_y
);
    assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/tmr_regfile_scrub.sv
// Triple-redundant 3-port register file with voted reads and a background scrubber.
module tmr_regfile_scrub
    import tmr_regfile_scrub_pkg::*;
#(
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned AW             = DEF_AW,
    parameter int unsigned SCRUB_INTERVAL = DEF_SCRUB_INTERVAL,
    parameter int unsigned CNTW           = DEF_CNTW
) (
    input logic                clk,
    input logic                reset,
    tmr_regfile_scrub_if.slave bus
);
    localparam int unsigned NREGS = 2 ** AW;
    localparam int unsigned WCW   = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

    logic [WIDTH-1:0] r_mem [3][NREGS];
    scrub_state_t     r_state;
    scrub_state_t     w_state_nxt;
    scrub_state_t     w_step_next;
    logic [WCW-1:0]   r_wait_cnt;
    logic [WCW-1:0]   w_cnt_nxt;
    logic             r_hit;
    logic             w_hit_nxt;
    logic [AW-1:0]    r_scrub_ptr;
    logic [AW-1:0]    w_ptr_inc;
    logic [WIDTH-1:0] r_maj;
    logic             w_latch;
    logic             w_ptr_adv;
    logic             w_fix_wr;
    logic             w_scrub_eq;
    logic             r_err_corr;
    logic [AW-1:0]    r_err_addr;
    logic [CNTW-1:0]  r_err_count;
    logic [WIDTH-1:0] w_rd1_vote;
    logic [WIDTH-1:0] w_rd2_vote;
    logic [WIDTH-1:0] w_scrub_vote;

    tmr_vote3 #(.WIDTH(WIDTH)) u_vote_rd1 (
        .i_a(r_mem[0][bus.ra1]), .i_b(r_mem[1][bus.ra1]), .i_c(r_mem[2][bus.ra1]), .o_y(w_rd1_vote)
    );
    tmr_vote3 #(.WIDTH(WIDTH)) u_vote_rd2 (
        .i_a(r_mem[0][bus.ra2]), .i_b(r_mem[1][bus.ra2]), .i_c(r_mem[2][bus.ra2]), .o_y(w_rd2_vote)
    );
    tmr_vote3 #(.WIDTH(WIDTH)) u_vote_scrub (
        .i_a(r_mem[0][r_scrub_ptr]), .i_b(r_mem[1][r_scrub_ptr]), .i_c(r_mem[2][r_scrub_ptr]),
        .o_y(w_scrub_vote)
    );

    // r0 always reads as zero regardless of what its copies hold
    assign bus.rd1 = (bus.ra1 == '0) ? '0 : w_rd1_vote;
    assign bus.rd2 = (bus.ra2 == '0) ? '0 : w_rd2_vote;

    assign w_scrub_eq = (r_mem[0][r_scrub_ptr] == r_mem[1][r_scrub_ptr]) &&
                        (r_mem[1][r_scrub_ptr] == r_mem[2][r_scrub_ptr]);
    assign w_ptr_inc  = (r_scrub_ptr == AW'(NREGS - 1)) ? AW'(1) : r_scrub_ptr + AW'(1);

    // Scrub FSM next state and step controls
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_hit_nxt   = r_hit;
        w_latch     = 1'b0;
        w_ptr_adv   = 1'b0;
        w_fix_wr    = 1'b0;
        w_step_next = bus.scrub_en ? WAIT : IDLE;
        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (bus.scrub_en) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (!bus.scrub_en) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_wait_cnt == WCW'(SCRUB_INTERVAL - 1)) begin
                    w_state_nxt = READ;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_wait_cnt + WCW'(1);
                end
            end
            READ: begin
                w_latch   = 1'b1;
                w_hit_nxt = bus.we3 && (bus.wa3 == r_scrub_ptr);
                if (w_scrub_eq) begin
                    w_ptr_adv   = 1'b1;
                    w_state_nxt = w_step_next;
                end else begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                // a CPU write to the entry makes the latched majority stale
                if (r_hit || (bus.we3 && (bus.wa3 == r_scrub_ptr))) begin
                    w_hit_nxt   = 1'b0;
                    w_ptr_adv   = 1'b1;
                    w_state_nxt = w_step_next;
                end else if (!bus.we3) begin
                    w_fix_wr    = 1'b1;
                    w_ptr_adv   = 1'b1;
                    w_state_nxt = w_step_next;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Scrub FSM state, interval counter, pointer and latched majority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_hit       <= 1'b0;
            r_scrub_ptr <= AW'(1);
            r_maj       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
            r_hit      <= w_hit_nxt;
            if (w_latch)   r_maj       <= w_scrub_vote;
            if (w_ptr_adv) r_scrub_ptr <= w_ptr_inc;
        end
    end

    // Correction pulse, last corrected address and saturating counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_corr  <= 1'b0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else begin
            r_err_corr <= w_fix_wr;
            if (w_fix_wr) begin
                r_err_addr <= r_scrub_ptr;
                if (r_err_count != '1) r_err_count <= r_err_count + CNTW'(1);
            end
        end
    end

    // Copy storage: injection, then scrub write-back, then CPU write (last one wins)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < int'(NREGS); i++) r_mem[k][i] <= '0;
            end
        end else begin
            if (bus.inj_en && (bus.inj_copy != 2'd3))
                r_mem[bus.inj_copy][bus.inj_addr] <= r_mem[bus.inj_copy][bus.inj_addr] ^ bus.inj_mask;
            if (w_fix_wr) begin
                for (int k = 0; k < 3; k++) r_mem[k][r_scrub_ptr] <= r_maj;
            end
            if (bus.we3 && (bus.wa3 != '0)) begin
                for (int k = 0; k < 3; k++) r_mem[k][bus.wa3] <= bus.wd3;
            end
        end
    end

    assign bus.err_corrected = r_err_corr;
    assign bus.err_addr      = r_err_addr;
    assign bus.err_count     = r_err_count;
    assign bus.scrub_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_tmr_regfile_scrub.sv
// Scoreboard bench for the triple-redundant register file and its scrubber.
`timescale 1ns/1ps
module tb_tmr_regfile_scrub;
    import tmr_regfile_scrub_pkg::*;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned CNTW   = 16;
    localparam int unsigned SI     = 16;
    localparam int unsigned CNTW_S = 2;
    localparam int unsigned SI_S   = 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   cnt;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic reset_s;
    int   total = 0;
    int   bad   = 0;

    ev_t              obs_q[$];
    ev_t              obs_s_q[$];
    ev_t              exp_ev_q[$];
    logic [WIDTH-1:0] rd_exp_q[$];

    always #5 clk = ~clk;

    tmr_regfile_scrub_if #(.WIDTH(WIDTH), .AW(AW), .CNTW(CNTW))   bus ();
    tmr_regfile_scrub_if #(.WIDTH(WIDTH), .AW(AW), .CNTW(CNTW_S)) bus_s ();

    tmr_regfile_scrub #(.WIDTH(WIDTH), .AW(AW), .SCRUB_INTERVAL(SI), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    tmr_regfile_scrub #(.WIDTH(WIDTH), .AW(AW), .SCRUB_INTERVAL(SI_S), .CNTW(CNTW_S)) dut_s (
        .clk(clk), .reset(reset_s), .bus(bus_s)
    );

    function automatic ev_t mk_ev(input logic [AW-1:0] a, input logic [15:0] c);
        ev_t e;
        e.addr = a;
        e.cnt  = c;
        return e;
    endfunction

    // Collect every correction pulse as it appears
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.err_corrected === 1'b1)
            obs_q.push_back(mk_ev(bus.err_addr, 16'(bus.err_count)));
        if (reset_s === 1'b1 && bus_s.err_corrected === 1'b1)
            obs_s_q.push_back(mk_ev(bus_s.err_addr, 16'(bus_s.err_count)));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        logic [WIDTH-1:0] e;
        {bus.we3, bus.wa3, bus.wd3, bus.scrub_en, bus.inj_en, bus.inj_addr, bus.inj_mask} = '0;
        {bus_s.we3, bus_s.wa3, bus_s.wd3, bus_s.scrub_en, bus_s.inj_en, bus_s.inj_addr, bus_s.inj_mask} = '0;
        bus.inj_copy = 2'd3; bus_s.inj_copy = 2'd3;
        bus_s.ra1 = '0; bus_s.ra2 = '0;
        bus.ra1 = AW'(7); bus.ra2 = '0;
        reset = 1'b0; reset_s = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1; reset_s = 1'b1;
        rd_exp_q.push_back('0); rd_exp_q.push_back('0);
        #1;
        e = rd_exp_q.pop_front(); total++;
        if (bus.rd1 !== e) begin bad++; $display("FAIL reset_rd1: got %h want %h", bus.rd1, e); end
        e = rd_exp_q.pop_front(); total++;
        if (bus.rd2 !== e) begin bad++; $display("FAIL reset_rd2: got %h want %h", bus.rd2, e); end
        total++;
        if (bus.err_count !== '0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.err_count); end
        total++;
        if (bus.scrub_busy !== 1'b0 || bus.err_corrected !== 1'b0 || bus.err_addr !== '0) begin
            bad++; $display("FAIL reset_status: got busy=%b pulse=%b addr=%0d want 0 0 0",
                            bus.scrub_busy, bus.err_corrected, bus.err_addr);
        end
    endtask

    task automatic test_write();
        logic [WIDTH-1:0] e;
        @(negedge clk);
        bus.we3 = 1'b1; bus.wa3 = AW'(5); bus.wd3 = 32'hDEADBEEF;
        rd_exp_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        bus.we3 = 1'b1; bus.wa3 = '0; bus.wd3 = 32'h0000_1234;
        bus.ra1 = AW'(5);
        #1;
        e = rd_exp_q.pop_front(); total++;
        if (bus.rd1 !== e) begin bad++; $display("FAIL write_r5: got %h want %h", bus.rd1, e); end
        @(negedge clk);
        bus.we3 = 1'b0;
        bus.ra2 = '0;
        rd_exp_q.push_back('0);
        #1;
        e = rd_exp_q.pop_front(); total++;
        if (bus.rd2 !== e) begin bad++; $display("FAIL write_r0: got %h want %h", bus.rd2, e); end
    endtask

    task automatic test_inject_scrub();
        logic [WIDTH-1:0] e;
        ev_t              o, x;
        bit               ok;
        @(negedge clk);
        bus.inj_en = 1'b1; bus.inj_copy = 2'd1; bus.inj_addr = AW'(5); bus.inj_mask = 32'h1;
        @(negedge clk);
        bus.inj_en = 1'b0; bus.inj_copy = 2'd3;
        bus.ra1 = AW'(5);
        rd_exp_q.push_back(32'hDEADBEEF);
        #1;
        e = rd_exp_q.pop_front(); total++;
        if (bus.rd1 !== e) begin bad++; $display("FAIL inj_vote_r5: got %h want %h", bus.rd1, e); end
        total++;
        if (dut.r_mem[1][5] !== 32'hDEADBEEE) begin
            bad++; $display("FAIL inj_landed: got %h want %h", dut.r_mem[1][5], 32'hDEADBEEE);
        end
        exp_ev_q.push_back(mk_ev(AW'(5), 16'd1));
        bus.scrub_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (obs_q.size() != 0) begin ok = 1'b1; break; end
        end
        x = exp_ev_q.pop_front(); total++;
        if (!ok) begin
            bad++; $display("FAIL scrub_r5_pulse: got none want addr=%0d cnt=%0d", x.addr, x.cnt);
        end else begin
            o = obs_q.pop_front();
            if (o !== x) begin
                bad++; $display("FAIL scrub_r5_pulse: got addr=%0d cnt=%0d want addr=%0d cnt=%0d",
                                o.addr, o.cnt, x.addr, x.cnt);
            end
        end
        total++;
        if (dut.r_mem[0][5] !== 32'hDEADBEEF || dut.r_mem[1][5] !== 32'hDEADBEEF ||
            dut.r_mem[2][5] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL scrub_r5_copies: got %h %h %h want %h", dut.r_mem[0][5],
                            dut.r_mem[1][5], dut.r_mem[2][5], 32'hDEADBEEF);
        end
    endtask

    task automatic test_write_hit();
        logic [WIDTH-1:0] e;
        bit               ok;
        @(negedge clk);
        bus.inj_en = 1'b1; bus.inj_copy = 2'd2; bus.inj_addr = AW'(9); bus.inj_mask = 32'hFF;
        @(negedge clk);
        bus.inj_en = 1'b0; bus.inj_copy = 2'd3;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (dut.r_state == FIX && dut.r_scrub_ptr == AW'(9)) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL hit_reach_fix9: got timeout want FIX at r9"); end
        bus.we3 = 1'b1; bus.wa3 = AW'(9); bus.wd3 = 32'hA5A5A5A5;
        rd_exp_q.push_back(32'hA5A5A5A5);
        @(negedge clk);
        bus.we3 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dut.r_scrub_ptr == AW'(11)) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok || obs_q.size() != 0) begin
            bad++; $display("FAIL hit_no_pulse: got pulses=%0d reached=%0b want 0 1", obs_q.size(), ok);
        end
        total++;
        if (bus.err_count !== CNTW'(1)) begin bad++; $display("FAIL hit_cnt: got %0d want 1", bus.err_count); end
        bus.ra1 = AW'(9);
        #1;
        e = rd_exp_q.pop_front(); total++;
        if (bus.rd1 !== e) begin bad++; $display("FAIL hit_rd_r9: got %h want %h", bus.rd1, e); end
        total++;
        if (dut.r_mem[2][9] !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL hit_copy2_r9: got %h want %h", dut.r_mem[2][9], 32'hA5A5A5A5);
        end
    endtask

    task automatic test_stall_sweep();
        logic [WIDTH-1:0] e;
        ev_t              o, x;
        bit               ok;
        bit               saw_zero;
        @(negedge clk);
        bus.inj_en = 1'b1; bus.inj_copy = 2'd0; bus.inj_addr = AW'(12); bus.inj_mask = 32'h0F0F0000;
        @(negedge clk);
        bus.inj_en = 1'b0; bus.inj_copy = 2'd3;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (dut.r_state == FIX && dut.r_scrub_ptr == AW'(12)) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL stall_reach_fix12: got timeout want FIX at r12"); end
        bus.we3 = 1'b1; bus.wa3 = AW'(3); bus.wd3 = 32'h33333333;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total++;
            if (bus.scrub_busy !== 1'b1 || bus.err_corrected !== 1'b0) begin
                bad++; $display("FAIL stall_cycle%0d: got busy=%b pulse=%b want 1 0",
                                i, bus.scrub_busy, bus.err_corrected);
            end
        end
        bus.we3 = 1'b0;
        exp_ev_q.push_back(mk_ev(AW'(12), 16'd2));
        @(negedge clk); #1;
        total++;
        if (bus.err_corrected !== 1'b1) begin
            bad++; $display("FAIL stall_fix_timing: got pulse=%b want 1", bus.err_corrected);
        end
        x = exp_ev_q.pop_front(); total++;
        if (obs_q.size() == 0) begin
            bad++; $display("FAIL stall_fix_event: got none want addr=%0d cnt=%0d", x.addr, x.cnt);
        end else begin
            o = obs_q.pop_front();
            if (o !== x) begin
                bad++; $display("FAIL stall_fix_event: got addr=%0d cnt=%0d want addr=%0d cnt=%0d",
                                o.addr, o.cnt, x.addr, x.cnt);
            end
        end
        bus.ra1 = AW'(3); bus.ra2 = AW'(12);
        rd_exp_q.push_back(32'h33333333); rd_exp_q.push_back('0);
        #1;
        e = rd_exp_q.pop_front(); total++;
        if (bus.rd1 !== e) begin bad++; $display("FAIL stall_rd_r3: got %h want %h", bus.rd1, e); end
        e = rd_exp_q.pop_front(); total++;
        if (bus.rd2 !== e || dut.r_mem[0][12] !== e) begin
            bad++; $display("FAIL stall_r12_clean: got %h copy0=%h want %h", bus.rd2, dut.r_mem[0][12], e);
        end
        saw_zero = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (dut.r_scrub_ptr == '0) saw_zero = 1'b1;
            if (dut.r_scrub_ptr == AW'(31)) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL sweep_reach31: got timeout want ptr=31"); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dut.r_scrub_ptr == '0) saw_zero = 1'b1;
            if (dut.r_scrub_ptr != AW'(31)) break;
        end
        total++;
        if (dut.r_scrub_ptr !== AW'(1)) begin
            bad++; $display("FAIL sweep_wrap: got ptr=%0d want 1", dut.r_scrub_ptr);
        end
        total++;
        if (saw_zero) begin bad++; $display("FAIL sweep_r0: got ptr=0 visited want never"); end
        bus.scrub_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.scrub_busy == 1'b0) break;
        end
        total++;
        if (bus.scrub_busy !== 1'b0) begin bad++; $display("FAIL scrub_stop: got busy=%b want 0", bus.scrub_busy); end
    endtask

    task automatic test_saturate_reset();
        ev_t o, x;
        bit  ok;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            bus_s.inj_en = 1'b1; bus_s.inj_copy = 2'(i % 3);
            bus_s.inj_addr = AW'(i); bus_s.inj_mask = 32'h1 << i;
            exp_ev_q.push_back(mk_ev(AW'(i), (i > 3) ? 16'd3 : 16'(i)));
        end
        @(negedge clk);
        bus_s.inj_en = 1'b0; bus_s.inj_copy = 2'd3;
        bus_s.scrub_en = 1'b1;
        for (int n = 0; n < 5; n++) begin
            ok = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk); #1;
                if (obs_s_q.size() != 0) begin ok = 1'b1; break; end
            end
            x = exp_ev_q.pop_front(); total++;
            if (!ok) begin
                bad++; $display("FAIL sat_event%0d: got none want addr=%0d cnt=%0d", n, x.addr, x.cnt);
            end else begin
                o = obs_s_q.pop_front();
                if (o !== x) begin
                    bad++; $display("FAIL sat_event%0d: got addr=%0d cnt=%0d want addr=%0d cnt=%0d",
                                    n, o.addr, o.cnt, x.addr, x.cnt);
                end
            end
        end
        total++;
        if (bus_s.err_count !== 2'd3) begin bad++; $display("FAIL sat_count: got %0d want 3", bus_s.err_count); end
        @(negedge clk);
        bus_s.inj_en = 1'b1; bus_s.inj_copy = 2'd1; bus_s.inj_addr = AW'(7); bus_s.inj_mask = 32'h80;
        @(negedge clk);
        bus_s.inj_en = 1'b0; bus_s.inj_copy = 2'd3;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dut_s.r_state == FIX && dut_s.r_scrub_ptr == AW'(7)) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL rst_reach_fix7: got timeout want FIX at r7"); end
        reset_s = 1'b0;
        #1;
        total++;
        if (bus_s.err_count !== '0 || bus_s.err_corrected !== 1'b0 || bus_s.scrub_busy !== 1'b0) begin
            bad++; $display("FAIL rst_midfix: got cnt=%0d pulse=%b busy=%b want 0 0 0",
                            bus_s.err_count, bus_s.err_corrected, bus_s.scrub_busy);
        end
        @(negedge clk);
        reset_s = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if (obs_s_q.size() != 0 || dut_s.r_mem[1][7] !== '0) begin
            bad++; $display("FAIL rst_no_writeback: got pulses=%0d copy1=%h want 0 0",
                            obs_s_q.size(), dut_s.r_mem[1][7]);
        end
        bus_s.scrub_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_inject_scrub();
        test_write_hit();
        test_stall_sweep();
        test_saturate_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
